// File: rtl/i2c_cmd_gen.sv
// i2c_cmd_gen: bit-level I2C engine. Executes one bus symbol (START,
// STOP, WRITE bit, READ bit) per accepted request, with runtime
// standard/fast speed, SCL clock-stretch timeout and arbitration-loss
// detection. SDA/SCL outputs are open-drain enables (1 = release).
module i2c_cmd_gen #(
  parameter int CLK_FREQ        = 25_000_000,
  parameter int I2C_FREQ        = 100_000,
  parameter int FAST_FREQ       = 400_000,
  parameter int STRETCH_TIMEOUT = 65535
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_enable,
  input  logic       i_req,
  input  logic [1:0] i_cmd,
  input  logic       i_wr_bit,
  input  logic       i_fast,
  output logic       o_ready,
  output logic       o_rd_valid,
  output logic       o_rd_bit,
  output logic       o_arb_lost,
  output logic       o_timeout,
  output logic       o_sda_drive,
  output logic       o_scl_drive,
  input  logic       i_sda,
  input  logic       i_scl
);

  // Quarter-period lengths in system clocks for each speed.
  localparam int Q_STD  = CLK_FREQ / (4 * I2C_FREQ);
  localparam int Q_FAST = CLK_FREQ / (4 * FAST_FREQ);
  localparam int Q_MAX  = (Q_STD > Q_FAST) ? Q_STD : Q_FAST;
  localparam int QW     = $clog2(Q_MAX + 1);
  localparam int SW     = $clog2(STRETCH_TIMEOUT + 1);
  // Cycles the SCL synchroniser needs before a release can be seen.
  localparam int SETTLE = 2;

  localparam logic [1:0] CMD_START = 2'd0;
  localparam logic [1:0] CMD_STOP  = 2'd1;
  localparam logic [1:0] CMD_WRITE = 2'd2;
  localparam logic [1:0] CMD_READ  = 2'd3;

  generate
    if (Q_STD < 2 || Q_FAST < 2) begin : g_bad_q
      $error("i2c_cmd_gen: quarter period must be at least 2 clocks");
    end
    if (STRETCH_TIMEOUT <= SETTLE) begin : g_bad_timeout
      $error("i2c_cmd_gen: STRETCH_TIMEOUT too small");
    end
  endgenerate

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PH_A,
    ST_PH_B,
    ST_PH_C,
    ST_PH_D
  } state_t;

  state_t          state_reg, state_next;
  logic [1:0]      cmd_reg, cmd_next;
  logic            wr_bit_reg, wr_bit_next;
  logic            fast_reg, fast_next;
  logic [QW-1:0]   q_cnt_reg, q_cnt_next;
  logic [SW-1:0]   stretch_cnt_reg, stretch_cnt_next;
  logic            scl_seen_reg, scl_seen_next;
  logic            rd_sample_reg, rd_sample_next;
  logic            rd_bit_reg, rd_bit_next;
  logic            rd_valid_reg, rd_valid_next;
  logic            arb_lost_reg, arb_lost_next;
  logic            timeout_reg, timeout_next;
  logic            sda_drive_reg, sda_drive_next;
  logic            scl_drive_reg, scl_drive_next;

  logic [1:0]      pad_in;
  logic [1:0]      pad_sync;
  logic            sda_s;
  logic            scl_s;
  logic            accept;
  logic [QW-1:0]   q_last;
  logic            q_done;

  // Pad synchronisers: bit 0 = SDA, bit 1 = SCL. Idle bus level is high.
  assign pad_in = {i_scl, i_sda};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
      logic meta_reg;
      logic sync_reg;
      // Two-flop synchroniser for one pad input.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          meta_reg <= 1'b1;
          sync_reg <= 1'b1;
        end else begin
          meta_reg <= pad_in[gi];
          sync_reg <= meta_reg;
        end
      end
      assign pad_sync[gi] = sync_reg;
    end
  endgenerate

  assign sda_s  = pad_sync[0];
  assign scl_s  = pad_sync[1];

  assign accept = i_req && (state_reg == ST_IDLE) && i_enable;
  assign q_last = fast_reg ? QW'(Q_FAST - 1) : QW'(Q_STD - 1);
  assign q_done = (q_cnt_reg == q_last);

  // FSM and datapath state registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg       <= ST_IDLE;
      cmd_reg         <= CMD_START;
      wr_bit_reg      <= 1'b0;
      fast_reg        <= 1'b0;
      q_cnt_reg       <= '0;
      stretch_cnt_reg <= '0;
      scl_seen_reg    <= 1'b0;
      rd_sample_reg   <= 1'b0;
    end else begin
      state_reg       <= state_next;
      cmd_reg         <= cmd_next;
      wr_bit_reg      <= wr_bit_next;
      fast_reg        <= fast_next;
      q_cnt_reg       <= q_cnt_next;
      stretch_cnt_reg <= stretch_cnt_next;
      scl_seen_reg    <= scl_seen_next;
      rd_sample_reg   <= rd_sample_next;
    end
  end

  // Registered outputs; reset releases both lines immediately.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sda_drive_reg <= 1'b1;
      scl_drive_reg <= 1'b1;
      rd_bit_reg    <= 1'b0;
      rd_valid_reg  <= 1'b0;
      arb_lost_reg  <= 1'b0;
      timeout_reg   <= 1'b0;
    end else begin
      sda_drive_reg <= sda_drive_next;
      scl_drive_reg <= scl_drive_next;
      rd_bit_reg    <= rd_bit_next;
      rd_valid_reg  <= rd_valid_next;
      arb_lost_reg  <= arb_lost_next;
      timeout_reg   <= timeout_next;
    end
  end

  // Next-state, phase timing, bus checks and line drives for the next cycle.
  always_comb begin
    state_next       = state_reg;
    cmd_next         = cmd_reg;
    wr_bit_next      = wr_bit_reg;
    fast_next        = fast_reg;
    q_cnt_next       = q_cnt_reg + QW'(1);
    stretch_cnt_next = stretch_cnt_reg;
    scl_seen_next    = scl_seen_reg;
    rd_sample_next   = rd_sample_reg;
    rd_bit_next      = rd_bit_reg;
    rd_valid_next    = 1'b0;
    arb_lost_next    = 1'b0;
    timeout_next     = 1'b0;
    sda_drive_next   = sda_drive_reg;
    scl_drive_next   = scl_drive_reg;

    case (state_reg)
      ST_IDLE: begin
        q_cnt_next = '0;
        if (accept) begin
          cmd_next    = i_cmd;
          wr_bit_next = i_wr_bit;
          fast_next   = i_fast;
          state_next  = ST_PH_A;
        end
      end
      ST_PH_A: begin
        if (q_done) begin
          state_next       = ST_PH_B;
          q_cnt_next       = '0;
          stretch_cnt_next = '0;
          scl_seen_next    = 1'b0;
        end
      end
      ST_PH_B: begin
        if (!scl_seen_reg) begin
          // Waiting for SCL high; the first settle cycles are never trusted
          // since the synchroniser still shows the pre-release level.
          q_cnt_next = '0;
          if ((stretch_cnt_reg >= SW'(SETTLE)) && scl_s) begin
            scl_seen_next = 1'b1;
            q_cnt_next    = QW'(1);
          end else if (stretch_cnt_reg == SW'(STRETCH_TIMEOUT - 1)) begin
            timeout_next = 1'b1;
          end else begin
            stretch_cnt_next = stretch_cnt_reg + SW'(1);
          end
        end else if (q_done) begin
          if ((cmd_reg == CMD_START) && !sda_s) begin
            arb_lost_next = 1'b1;
          end else begin
            state_next = ST_PH_C;
            q_cnt_next = '0;
          end
        end
      end
      ST_PH_C: begin
        if (q_done) begin
          if (cmd_reg == CMD_READ) begin
            rd_sample_next = sda_s;
          end
          if ((cmd_reg == CMD_WRITE) && wr_bit_reg && !sda_s) begin
            arb_lost_next = 1'b1;
          end else begin
            state_next = ST_PH_D;
            q_cnt_next = '0;
          end
        end
      end
      ST_PH_D: begin
        if (q_done) begin
          if ((cmd_reg == CMD_STOP) && !sda_s) begin
            arb_lost_next = 1'b1;
          end else begin
            state_next = ST_IDLE;
            q_cnt_next = '0;
            if (cmd_reg == CMD_READ) begin
              rd_bit_next   = rd_sample_reg;
              rd_valid_next = 1'b1;
            end
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    if (arb_lost_next || timeout_next) begin
      // Abort: give the bus back and return to idle.
      state_next     = ST_IDLE;
      q_cnt_next     = '0;
      sda_drive_next = 1'b1;
      scl_drive_next = 1'b1;
    end else begin
      case (state_next)
        ST_PH_A: begin
          case (cmd_next)
            CMD_WRITE: begin sda_drive_next = wr_bit_next; scl_drive_next = 1'b0; end
            CMD_READ:  begin sda_drive_next = 1'b1;        scl_drive_next = 1'b0; end
            CMD_START: begin sda_drive_next = 1'b1;        scl_drive_next = scl_drive_reg; end
            default:   begin sda_drive_next = 1'b0;        scl_drive_next = 1'b0; end
          endcase
        end
        ST_PH_B: begin
          scl_drive_next = 1'b1;
          case (cmd_next)
            CMD_WRITE: sda_drive_next = wr_bit_next;
            CMD_STOP:  sda_drive_next = 1'b0;
            default:   sda_drive_next = 1'b1;
          endcase
        end
        ST_PH_C: begin
          scl_drive_next = 1'b1;
          case (cmd_next)
            CMD_WRITE: sda_drive_next = wr_bit_next;
            CMD_START: sda_drive_next = 1'b0;
            default:   sda_drive_next = 1'b1;
          endcase
        end
        ST_PH_D: begin
          case (cmd_next)
            CMD_WRITE: begin sda_drive_next = wr_bit_next; scl_drive_next = 1'b0; end
            CMD_START: begin sda_drive_next = 1'b0;        scl_drive_next = 1'b0; end
            CMD_STOP:  begin sda_drive_next = 1'b1;        scl_drive_next = 1'b1; end
            default:   begin sda_drive_next = 1'b1;        scl_drive_next = 1'b0; end
          endcase
        end
        default: begin
          // Idle: lines keep whatever the last symbol left them at.
          sda_drive_next = sda_drive_reg;
          scl_drive_next = scl_drive_reg;
        end
      endcase
    end
  end

  assign o_ready     = (state_reg == ST_IDLE);
  assign o_rd_valid  = rd_valid_reg;
  assign o_rd_bit    = rd_bit_reg;
  assign o_arb_lost  = arb_lost_reg;
  assign o_timeout   = timeout_reg;
  assign o_sda_drive = sda_drive_reg;
  assign o_scl_drive = scl_drive_reg;

endmodule

// File: tb/tb_i2c_cmd_gen.sv
// Bench for i2c_cmd_gen: open-drain bus model with a slave that can pull
// SDA low and stretch SCL, randomized READ/WRITE traffic and a
// symbol-level reference model (lengths, read data, pulses).
module tb_i2c_cmd_gen;

  localparam int CLK_FREQ  = 25_000_000;
  localparam int I2C_FREQ  = 100_000;
  localparam int FAST_FREQ = 400_000;
  localparam int TMO       = 100;
  localparam int QS        = CLK_FREQ / (4 * I2C_FREQ);
  localparam int QF        = CLK_FREQ / (4 * FAST_FREQ);

  localparam logic [1:0] C_START = 2'd0;
  localparam logic [1:0] C_STOP  = 2'd1;
  localparam logic [1:0] C_WRITE = 2'd2;
  localparam logic [1:0] C_READ  = 2'd3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable, req, wr_bit, fast;
  logic [1:0] cmd;
  logic       ready, rd_valid, rd_bit, arb_lost, timeout_p;
  logic       sda_drive, scl_drive;
  logic       sda_pull, scl_hold;
  logic       sda_bus, scl_bus;

  // Wired-AND bus: released lines float high unless someone pulls them low.
  assign sda_bus = sda_drive & ~sda_pull;
  assign scl_bus = scl_drive & ~scl_hold;

  always #5 clk = ~clk;

  i2c_cmd_gen #(
    .CLK_FREQ        (CLK_FREQ),
    .I2C_FREQ        (I2C_FREQ),
    .FAST_FREQ       (FAST_FREQ),
    .STRETCH_TIMEOUT (TMO)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_enable    (enable),
    .i_req       (req),
    .i_cmd       (cmd),
    .i_wr_bit    (wr_bit),
    .i_fast      (fast),
    .o_ready     (ready),
    .o_rd_valid  (rd_valid),
    .o_rd_bit    (rd_bit),
    .o_arb_lost  (arb_lost),
    .o_timeout   (timeout_p),
    .o_sda_drive (sda_drive),
    .o_scl_drive (scl_drive),
    .i_sda       (sda_bus),
    .i_scl       (scl_bus)
  );

  int total = 0;
  int bad   = 0;

  // Per-symbol observations collected by run_sym.
  int   r_len, r_rdv, r_arb, r_to;
  logic r_wr_bad, r_fall, r_rise, r_rd_end, r_rdv_end;
  logic last_rd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int qof(input logic f);
    return f ? QF : QS;
  endfunction

  // Issue one symbol and watch the bus until o_ready returns.
  // stretch: cycles the slave keeps SCL low after the engine releases it.
  task automatic run_sym(input logic [1:0] c, input logic b, input logic f,
                         input int stretch, input logic slave_low);
    int   hold_left;
    int   cyc;
    logic p_sda, p_scl;
    cmd       = c;
    wr_bit    = b;
    fast      = f;
    sda_pull  = slave_low;
    hold_left = stretch;
    scl_hold  = (stretch > 0);
    req       = 1'b1;
    @(negedge clk);
    req       = 1'b0;
    check("busy_after_accept", ready, 1'b0);
    r_rdv = 0; r_arb = 0; r_to = 0;
    r_wr_bad = 1'b0; r_fall = 1'b0; r_rise = 1'b0;
    cyc   = 0;
    p_sda = sda_bus;
    p_scl = scl_bus;
    while (1) begin
      if ((c == C_WRITE) && scl_bus && (sda_bus !== b)) r_wr_bad = 1'b1;
      if (cyc > 0) begin
        if (p_scl && scl_bus && p_sda && !sda_bus) r_fall = 1'b1;
        if (p_scl && scl_bus && !p_sda && sda_bus) r_rise = 1'b1;
      end
      p_sda = sda_bus;
      p_scl = scl_bus;
      if (rd_valid)  r_rdv++;
      if (arb_lost)  r_arb++;
      if (timeout_p) r_to++;
      if (ready) break;
      if (cyc >= 3000) begin
        check("symbol_cycle_bound", cyc, 0);
        break;
      end
      if (scl_hold && scl_drive) begin
        if (hold_left == 0) scl_hold = 1'b0;
        else hold_left--;
      end
      @(negedge clk);
      cyc++;
    end
    r_len     = cyc;
    r_rd_end  = rd_bit;
    r_rdv_end = rd_valid;
    scl_hold  = 1'b0;
    $display("sym cmd=%0d bit=%0d fast=%0d stretch=%0d len=%0d rdv=%0d rd=%0d arb=%0d to=%0d",
             c, b, f, stretch, r_len, r_rdv, r_rd_end, r_arb, r_to);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: time limit reached observed=0 expected=1");
    $fatal(1, "watchdog");
  end

  initial begin
    logic b, f;
    logic [1:0] c;
    int   st;
    rst_n = 1'b0; enable = 1'b1; req = 1'b0; cmd = C_START;
    wr_bit = 1'b0; fast = 1'b0; sda_pull = 1'b0; scl_hold = 1'b0;
    last_rd = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready",    ready,     1'b1);
    check("rst_sda",      sda_drive, 1'b1);
    check("rst_scl",      scl_drive, 1'b1);
    check("rst_rd_bit",   rd_bit,    1'b0);
    check("rst_rd_valid", rd_valid,  1'b0);
    check("rst_pulses",   {30'b0, arb_lost, timeout_p}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Disabled engine ignores requests.
    enable = 1'b0; req = 1'b1; cmd = C_WRITE;
    repeat (4) @(negedge clk);
    check("enable_gate_ready", ready, 1'b1);
    req = 1'b0; enable = 1'b1;
    @(negedge clk);

    // START from idle.
    run_sym(C_START, 1'b0, 1'b0, 0, 1'b0);
    check("start_len",  r_len, 4*QS+2);
    check("start_fall", r_fall, 1'b1);
    check("start_arb",  r_arb, 0);

    // WRITE 1,0,1,0.
    for (int i = 0; i < 4; i++) begin
      b = (i % 2 == 0);
      run_sym(C_WRITE, b, 1'b0, 0, 1'b0);
      check("wr_len",    r_len, 4*QS+2);
      check("wr_sda",    r_wr_bad, 1'b0);
      check("wr_arb",    r_arb, 0);
      check("wr_rdv",    r_rdv, 0);
    end

    // READ x8, slave presents random bits.
    for (int i = 0; i < 8; i++) begin
      b = 1'($urandom_range(0, 1));
      run_sym(C_READ, 1'b0, 1'b0, 0, ~b);
      last_rd = b;
      check("rd_len",       r_len, 4*QS+2);
      check("rd_valid_cnt", r_rdv, 1);
      check("rd_valid_end", r_rdv_end, 1'b1);
      check("rd_bit",       r_rd_end, b);
    end

    // READ with 20-cycle clock stretch.
    b = 1'($urandom_range(0, 1));
    run_sym(C_READ, 1'b0, 1'b0, 20, ~b);
    last_rd = b;
    check("stretch_len", r_len, 4*QS+2+20);
    check("stretch_bit", r_rd_end, b);
    check("stretch_to",  r_to, 0);

    // Randomized READ/WRITE mix with random speed and stretch.
    for (int i = 0; i < 16; i++) begin
      c  = ($urandom_range(0, 1) == 0) ? C_READ : C_WRITE;
      b  = 1'($urandom_range(0, 1));
      f  = 1'($urandom_range(0, 1));
      st = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 30)) : 0;
      if (c == C_READ) begin
        run_sym(C_READ, 1'b0, f, st, ~b);
        last_rd = b;
        check("mix_rd_bit", r_rd_end, b);
        check("mix_rd_rdv", r_rdv, 1);
      end else begin
        run_sym(C_WRITE, b, f, st, 1'b0);
        check("mix_wr_sda", r_wr_bad, 1'b0);
        check("mix_wr_rdv", r_rdv, 0);
        check("mix_rd_hold", r_rd_end, last_rd);
      end
      check("mix_len", r_len, 4*qof(f)+2+st);
      check("mix_abort", r_arb + r_to, 0);
    end

    // Slave holds SCL low for 200 cycles: timeout after TMO waiting cycles.
    run_sym(C_READ, 1'b0, 1'b0, 200, 1'b0);
    check("to_pulses", r_to, 1);
    check("to_len",    r_len, QS+TMO);
    check("to_rdv",    r_rdv, 0);
    check("to_sda",    sda_drive, 1'b1);
    check("to_scl",    scl_drive, 1'b1);
    check("to_rd_hold", r_rd_end, last_rd);

    // Arbitration loss on WRITE 1.
    run_sym(C_START, 1'b0, 1'b0, 0, 1'b0);
    check("start2_len", r_len, 4*QS+2);
    run_sym(C_WRITE, 1'b1, 1'b0, 0, 1'b1);
    check("arb_pulses", r_arb, 1);
    check("arb_len",    r_len, 3*QS+2);
    check("arb_rdv",    r_rdv, 0);
    check("arb_sda",    sda_drive, 1'b1);
    check("arb_scl",    scl_drive, 1'b1);

    // Fast START then STOP.
    run_sym(C_START, 1'b0, 1'b1, 0, 1'b0);
    check("fstart_len",  r_len, 4*QF+2);
    check("fstart_fall", r_fall, 1'b1);
    check("fstart_arb",  r_arb, 0);
    run_sym(C_STOP, 1'b0, 1'b1, 0, 1'b0);
    check("fstop_len",  r_len, 4*QF+2);
    check("fstop_rise", r_rise, 1'b1);
    check("fstop_arb",  r_arb, 0);
    repeat (3) @(negedge clk);
    check("idle_sda", sda_drive, 1'b1);
    check("idle_scl", scl_drive, 1'b1);

    // Reset asserted in the middle of a STOP.
    run_sym(C_START, 1'b0, 1'b1, 0, 1'b0);
    check("rstart_len", r_len, 4*QF+2);
    cmd = C_STOP; fast = 1'b1; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    repeat (30) @(negedge clk);
    check("mid_stop_sda_low", sda_drive, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_sda",   sda_drive, 1'b1);
    check("mid_rst_scl",   scl_drive, 1'b1);
    check("mid_rst_ready", ready,     1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Engine works again after reset.
    run_sym(C_START, 1'b0, 1'b0, 0, 1'b0);
    check("post_rst_len", r_len, 4*QS+2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2c_cmd_gen.md
Name: i2c_cmd_gen

Overview:
Second-generation I2C bit-level engine. Executes one bus symbol per request: START/repeated START, STOP, WRITE bit or READ bit. Adds runtime standard/fast speed select, clock-stretch timeout and multi-master arbitration-loss detection. Sits under the byte/transaction controller and drives the open-drain SDA/SCL pads.

Parameters:
CLK_FREQ, 25_000_000, system clock frequency in Hz.
I2C_FREQ, 100_000, SCL frequency used when i_fast=0.
FAST_FREQ, 400_000, SCL frequency used when i_fast=1.
STRETCH_TIMEOUT, 65535, maximum number of cycles the slave may hold SCL low in phase B.

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_enable  in  1  engine enable; gates request acceptance only
i_req  in  1  symbol request
i_cmd  in  2  0=START, 1=STOP, 2=WRITE, 3=READ
i_wr_bit  in  1  bit to send for WRITE
i_fast  in  1  speed select, sampled at accept
o_ready  out  1  idle, able to accept a request
o_rd_valid  out  1  one-cycle pulse, o_rd_bit valid
o_rd_bit  out  1  sampled READ bit
o_arb_lost  out  1  one-cycle pulse, arbitration lost
o_timeout  out  1  one-cycle pulse, stretch timeout
o_sda_drive  out  1  1=release SDA, 0=pull low
o_scl_drive  out  1  1=release SCL, 0=pull low
i_sda  in  1  SDA pad level
i_scl  in  1  SCL pad level

Behaviour:
- Reset (async assert, sync deassert use): o_sda_drive=1, o_scl_drive=1, o_ready=1, o_rd_bit=0, all pulses 0, FSM=IDLE. Assertion mid-symbol releases both lines immediately.
- i_sda/i_scl pass through 2-flop synchronisers; every "sampled" level below is the synchronised value.
- Quarter period Q = CLK_FREQ/(4*freq), with freq selected by i_fast latched at accept. Elaboration error if Q<2. Defaults: Q=62 standard, Q=15 fast.
- Accept: i_req && o_ready && i_enable at a rising edge. i_cmd, i_wr_bit and i_fast are latched; o_ready=0 from the next cycle. A request arriving while busy is ignored.
- FSM: IDLE -> PH_A -> PH_B -> PH_C -> PH_D -> IDLE. PH_A, PH_C and PH_D each last exactly Q cycles.
- PH_B releases SCL, then waits for SCL to be sampled high. While it waits, a stretch counter increments. The Q-cycle count starts on the first high sample. Unstretched symbol length is 4Q+2 cycles.
- Drive per phase (A/B/C/D):
  - WRITE b: SDA=b in all phases; SCL low/rel/rel/low.
  - READ: SDA released in all phases; SCL low/rel/rel/low. The bit is sampled on the last cycle of C.
  - START: SDA rel/rel/low/low. SCL keeps its previous drive in A (low for repeated START, high from idle), then rel/rel/low.
  - STOP: SDA low/low/rel/rel; SCL low/rel/rel/rel.
- Drive outputs persist in IDLE: SCL stays low after WRITE/READ/START and is released after STOP.
- Completion: o_ready returns to 1 on the cycle after the last PH_D cycle. For READ, o_rd_valid pulses in the same cycle and o_rd_bit holds until the next READ completes.
- Arbitration lost: WRITE with b=1, and SDA sampled low on the last cycle of C; START, and SDA sampled low on the last cycle of B; STOP, and SDA sampled low on the last cycle of D. Response: release SDA and SCL next cycle, pulse o_arb_lost, go to IDLE (o_ready=1). No o_rd_valid.
- Timeout: stretch counter reaches STRETCH_TIMEOUT in PH_B. Response: release both lines, pulse o_timeout, go to IDLE.
- i_enable low never aborts an accepted symbol.

Test Plan:
- WRITE 1,0,1,0 at Q=62, no stretch -> SDA equals the bit while SCL is high; each symbol 250 cycles accept-to-ready; o_arb_lost=0.
- READ x8 with the bench toggling SDA while SCL is low -> o_rd_valid pulses 8 times; o_rd_bit equals the bench SDA each time.
- READ with slave holding SCL low 20 cycles in PH_B -> symbol length 270 cycles; bit correct; o_timeout=0.
- STRETCH_TIMEOUT=100 with SCL held low 200 cycles -> o_timeout pulses once at stretch count 100; both drives 1; o_ready=1.
- WRITE 1 with bench forcing SDA low -> o_arb_lost pulses; SDA and SCL released; next START accepted.
- START, then STOP with i_fast=1 (Q=15) -> SDA falls while SCL is high, then rises while SCL is high; each symbol 62 cycles; idle ends with both drives 1. Repeat with reset asserted mid-STOP -> both drives 1 immediately.
